compute_arbiter: RTL and testbench

COMPUTE_ARBITER -- requirements
Module: compute_arbiter

---
 rtl/compute_arbiter.sv | 163 ++++++++++++++++
 tb/tb_compute_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : compute_arbiter
//  Description : Round-robin arbiter that shares one compute engine among
//                NUM_UNITS requesters. Requests are latched into a pending
//                register, served one at a time, and completed either by the
//                engine's done pulse or by a busy-cycle timeout.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             : clock, all logic on the rising edge
//    rst             : synchronous active-high reset
//    compute_request : per-unit single-cycle request pulse
//    compute_ready   : per-unit "a request will be accepted"
//    compute_done    : per-unit single-cycle completion pulse
//    eng_start       : single-cycle start pulse to the engine
//    eng_unit_id     : unit owning the engine (valid from eng_start to end of BUSY)
//    eng_done        : engine completion pulse
//    busy            : high whenever the arbiter is not idle
//    err_timeout     : sticky, engine failed to finish in time
//    err_overrun     : sticky, a request hit an already-pending unit
// ============================================================================
module compute_arbiter #(
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] compute_request,
  output logic [NUM_UNITS-1:0] compute_ready,
  output logic [NUM_UNITS-1:0] compute_done,
  output logic                 eng_start,
  output logic [1:0]           eng_unit_id,
  input  logic                 eng_done,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_UNITS-1:0] pending_q, pending_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic [1:0]           unit_id_q, unit_id_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_overrun_q, err_overrun_d;

  logic [1:0]           sel_w;
  logic                 sel_valid_w;
  logic                 start_w;
  logic [NUM_UNITS-1:0] done_vec_w;

  // Round-robin pick: scan from last_grant+1 upward, wrapping to 0, and take
  // the first pending unit found.
  always_comb begin : p_rr
    logic [1:0] idx;
    idx         = '0;
    sel_w       = '0;
    sel_valid_w = 1'b0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      idx = 2'((int'(last_grant_q) + k) % NUM_UNITS);
      if (!sel_valid_w && pending_q[idx]) begin
        sel_valid_w = 1'b1;
        sel_w       = idx;
      end
    end
  end

  assign start_w = (state_q == ST_IDLE) && sel_valid_w;

  // One-hot of the owning unit during DONE; doubles as the pending clear mask.
  always_comb begin
    done_vec_w = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      done_vec_w[i] = (state_q == ST_DONE) && (unit_id_q == 2'(i));
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    last_grant_d  = last_grant_q;
    unit_id_d     = unit_id_q;
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid_w) begin
          unit_id_d = sel_w;
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // A done arriving on the timeout cycle is a normal completion.
        if (eng_done) begin
          state_d = ST_DONE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        pending_d    = pending_q & ~done_vec_w;
        last_grant_d = unit_id_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Request handling after the clear so a new request for the unit being
    // completed re-arms it instead of counting as an overrun.
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (compute_request[i]) begin
        if (pending_q[i] && !done_vec_w[i]) begin
          err_overrun_d = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      last_grant_q  <= 2'(NUM_UNITS - 1);
      unit_id_q     <= '0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      last_grant_q  <= last_grant_d;
      unit_id_q     <= unit_id_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign compute_ready = (state_q == ST_IDLE) ? ~pending_q : '0;
  assign compute_done  = done_vec_w;
  assign eng_start     = start_w;
  // During the start cycle the selection is not registered yet, so forward it.
  assign eng_unit_id   = start_w ? sel_w : unit_id_q;
  assign busy          = (state_q != ST_IDLE);
  assign err_timeout   = err_timeout_q;
  assign err_overrun   = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_compute_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compute_arbiter
//  Description : Directed self-checking bench for compute_arbiter.
//                Inputs are driven and outputs sampled 1 time unit after each
//                rising edge ("interval" following that edge).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compute_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] compute_request;
  logic [3:0] compute_ready;
  logic [3:0] compute_done;
  logic       eng_start;
  logic [1:0] eng_unit_id;
  logic       eng_done;
  logic       busy;
  logic       err_timeout;
  logic       err_overrun;

  int checks   = 0;
  int failures = 0;

  compute_arbiter #(.NUM_UNITS(4), .TIMEOUT_CYCLES(255)) dut (
    .clk             (clk),
    .rst             (rst),
    .compute_request (compute_request),
    .compute_ready   (compute_ready),
    .compute_done    (compute_done),
    .eng_start       (eng_start),
    .eng_unit_id     (eng_unit_id),
    .eng_done        (eng_done),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .err_overrun     (err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; compute_request = '0; eng_done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v);
    compute_request = v;
    step();
    compute_request = '0;
  endtask

  // Waits (bounded) for eng_start, runs the engine, and returns what was seen.
  // inj_busy is requested in the first BUSY cycle, inj_done in the DONE cycle.
  // Returns in the interval after DONE (IDLE).
  task automatic serve(input int lat, input logic [3:0] inj_busy,
                       input logic [3:0] inj_done, output bit started,
                       output logic [1:0] id, output logic [3:0] dvec);
    int n;
    started = 1'b0; id = '0; dvec = '0; n = 0;
    while (!eng_start && n < 10) begin step(); n++; end
    if (eng_start) begin
      started = 1'b1;
      id = eng_unit_id;
      step();
      compute_request = inj_busy; step(); compute_request = '0;
      repeat (lat) step();
      eng_done = 1'b1; step(); eng_done = 1'b0;
      dvec = compute_done;
      compute_request = inj_done; step(); compute_request = '0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, eng_start, compute_done, compute_ready, eng_unit_id, err_timeout, err_overrun}
        !== {1'b0, 1'b0, 4'b0000, 4'b1111, 2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: busy=%b start=%b done=%b ready=%b id=%0d tmo=%b ovr=%b expected 0 0 0000 1111 0 0 0",
               busy, eng_start, compute_done, compute_ready, eng_unit_id, err_timeout, err_overrun);
    end
  endtask

  task automatic test_single();
    do_reset();
    pulse(4'b0001);                       // cycle 2
    checks++;
    if ({eng_start, eng_unit_id, compute_ready} !== {1'b1, 2'd0, 4'b1110}) begin
      failures++;
      $display("FAIL single_start: start=%b id=%0d ready=%b expected 1 0 1110", eng_start, eng_unit_id, compute_ready);
    end
    step();                               // cycle 3
    checks++;
    if ({eng_start, busy} !== 2'b01) begin
      failures++;
      $display("FAIL single_busy: start=%b busy=%b expected 0 1", eng_start, busy);
    end
    step(); step(); step();               // cycle 6
    eng_done = 1'b1; step(); eng_done = 1'b0;  // cycle 7
    checks++;
    if ({compute_done, compute_ready} !== {4'b0001, 4'b0000}) begin
      failures++;
      $display("FAIL single_done: done=%b ready=%b expected 0001 0000", compute_done, compute_ready);
    end
    step();                               // cycle 8
    checks++;
    if ({compute_done, compute_ready, busy} !== {4'b0000, 4'b1111, 1'b0}) begin
      failures++;
      $display("FAIL single_ready: done=%b ready=%b busy=%b expected 0000 1111 0", compute_done, compute_ready, busy);
    end
  endtask

  task automatic test_contention();
    bit s; logic [1:0] id; logic [3:0] d;
    logic [1:0] exp_id [3];
    bit seen_start;
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd3;
    do_reset();
    pulse(4'b1011);
    for (int j = 0; j < 3; j++) begin
      serve(2, 4'b0000, 4'b0000, s, id, d);
      checks++;
      if (!s || id !== exp_id[j] || d !== (4'b0001 << exp_id[j])) begin
        failures++;
        $display("FAIL contention_grant%0d: started=%b id=%0d done=%b expected 1 %0d %b",
                 j, s, id, d, exp_id[j], 4'b0001 << exp_id[j]);
      end
    end
    seen_start = 1'b0;
    repeat (4) begin
      if (eng_start) seen_start = 1'b1;
      step();
    end
    checks++;
    if (seen_start !== 1'b0) begin
      failures++;
      $display("FAIL no_start_when_empty: eng_start seen=%b expected 0", seen_start);
    end
  endtask

  task automatic test_fairness();
    bit s; logic [1:0] id; logic [3:0] d;
    logic [1:0] exp_id [3];
    exp_id[0] = 2'd1; exp_id[1] = 2'd2; exp_id[2] = 2'd0;
    do_reset();
    pulse(4'b0010);
    for (int j = 0; j < 3; j++) begin
      // Units 0 and 2 request while unit 1 is busy, leaving last_grant=1.
      serve(1, (j == 0) ? 4'b0101 : 4'b0000, 4'b0000, s, id, d);
      checks++;
      if (!s || id !== exp_id[j] || d !== (4'b0001 << exp_id[j])) begin
        failures++;
        $display("FAIL fairness_grant%0d: started=%b id=%0d done=%b expected 1 %0d %b",
                 j, s, id, d, exp_id[j], 4'b0001 << exp_id[j]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    pulse(4'b0001);
    n = 0;
    // Counter is 0 in the first BUSY cycle, reaches 255 in the 256th; DONE follows.
    while (compute_done === 4'b0000 && n < 400) begin step(); n++; end
    checks++;
    if (n != 257 || compute_done !== 4'b0001 || err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_done: cycles=%0d done=%b tmo=%b expected 257 0001 1", n, compute_done, err_timeout);
    end
    step(); step(); step();
    checks++;
    if ({err_timeout, busy, compute_ready} !== {1'b1, 1'b0, 4'b1111}) begin
      failures++;
      $display("FAIL timeout_sticky: tmo=%b busy=%b ready=%b expected 1 0 1111", err_timeout, busy, compute_ready);
    end
  endtask

  task automatic test_done_at_limit();
    do_reset();
    pulse(4'b0001);
    repeat (256) step();                  // BUSY, counter == 255
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL limit_still_busy: busy=%b expected 1", busy);
    end
    eng_done = 1'b1; step(); eng_done = 1'b0;
    checks++;
    if ({compute_done, err_timeout} !== {4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL limit_normal_done: done=%b tmo=%b expected 0001 0", compute_done, err_timeout);
    end
  endtask

  task automatic test_overrun();
    bit s; logic [1:0] id; logic [3:0] d;
    bit seen_start;
    do_reset();
    pulse(4'b0100);                       // start cycle, pending[2]=1
    compute_request = 4'b0100; step(); compute_request = '0;
    checks++;
    if ({err_overrun, busy} !== 2'b11) begin
      failures++;
      $display("FAIL overrun_flag: ovr=%b busy=%b expected 1 1", err_overrun, busy);
    end
    eng_done = 1'b1; step(); eng_done = 1'b0;
    checks++;
    if (compute_done !== 4'b0100) begin
      failures++;
      $display("FAIL overrun_done: done=%b expected 0100", compute_done);
    end
    step();
    seen_start = 1'b0;
    repeat (4) begin
      if (eng_start) seen_start = 1'b1;
      step();
    end
    checks++;
    if ({seen_start, compute_ready, err_overrun} !== {1'b0, 4'b1111, 1'b1}) begin
      failures++;
      $display("FAIL overrun_once: restart=%b ready=%b ovr=%b expected 0 1111 1", seen_start, compute_ready, err_overrun);
    end
    // Request in the DONE cycle for the granted unit: set wins, no overrun.
    do_reset();
    pulse(4'b0100);
    serve(1, 4'b0000, 4'b0100, s, id, d);
    checks++;
    if ({eng_start, eng_unit_id, err_overrun} !== {1'b1, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL set_wins: start=%b id=%0d ovr=%b expected 1 2 0", eng_start, eng_unit_id, err_overrun);
    end
    serve(1, 4'b0000, 4'b0000, s, id, d);
  endtask

  task automatic test_reset_mid_busy();
    bit seen_done;
    do_reset();
    pulse(4'b0001);
    step(); step();                       // BUSY
    rst = 1'b1; step(); rst = 1'b0;
    seen_done = (compute_done !== 4'b0000);
    checks++;
    if ({busy, compute_ready, compute_done} !== {1'b0, 4'b1111, 4'b0000}) begin
      failures++;
      $display("FAIL reset_mid_busy: busy=%b ready=%b done=%b expected 0 1111 0000", busy, compute_ready, compute_done);
    end
    eng_done = 1'b1;                      // ignored in IDLE
    repeat (4) begin
      step();
      if (compute_done !== 4'b0000 || eng_start) seen_done = 1'b1;
      eng_done = 1'b0;
    end
    checks++;
    if ({seen_done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_abandon: activity=%b busy=%b expected 0 0", seen_done, busy);
    end
  endtask

  initial begin
    rst = 1'b1; compute_request = '0; eng_done = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_done_at_limit();
    test_overrun();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
